mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_pkg.sv | 41 ++++
 rtl/timer_unit.sv | 87 ++++++++
 rtl/mem_bus_responder.sv | 93 +++++++++
 tb/tb_mem_bus_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-map constants, timer control fields and types for the CPU memory-port responder.
package mem_bus_pkg;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned WADDR_W   = ADDR_W - 2;
   localparam int unsigned RAM_DEPTH = 256;
   localparam int unsigned RAM_IDX_W = 8;
   localparam int unsigned CTRL_W    = 3;

   localparam logic [ADDR_W-1:0] RAM_TOP    = 32'h0000_03FF;
   localparam logic [ADDR_W-1:0] TIMER_CNT  = 32'h0000_0400;
   localparam logic [ADDR_W-1:0] TIMER_CMP  = 32'h0000_0404;
   localparam logic [ADDR_W-1:0] TIMER_CTRL = 32'h0000_0408;
   localparam logic [ADDR_W-1:0] TIMER_STAT = 32'h0000_040C;
   localparam logic [ADDR_W-1:0] MAP_END    = 32'h0000_0410;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_IRQEN   = 1;
   localparam int unsigned CTRL_AUTORLD = 2;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUNNING = 2'd1,
      EXPIRED = 2'd2
   } timer_state_e;

   // Decoded register write strobes plus write data, handed from the bus decode to the timer.
   typedef struct packed {
      logic              wr_cnt;
      logic              wr_cmp;
      logic              wr_ctrl;
      logic              wr_stat;
      logic [DATA_W-1:0] wdata;
   } timer_wr_t;

   function automatic logic [WADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/timer_unit.sv
// Compare timer: counter, compare, control and match status, with a STOPPED/RUNNING/EXPIRED controller.
module timer_unit
   import mem_bus_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  timer_wr_t         wr_i,
   output logic [DATA_W-1:0] cnt_o,
   output logic [DATA_W-1:0] cmp_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              match_o,
   output logic              irq_o
);

   timer_state_e      state_q, state_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] cmp_q, cmp_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              match_q, match_d;
   logic              irq_q, irq_d;
   logic              hit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= STOPPED;
         cnt_q   <= '0;
         cmp_q   <= '1;
         ctrl_q  <= '0;
         match_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         match_q <= match_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      ctrl_d  = ctrl_q;
      match_d = match_q;
      hit     = 1'b0;

      case (state_q)
         STOPPED: begin
            if (ctrl_q[CTRL_EN]) state_d = RUNNING;
         end
         RUNNING: begin
            if (!ctrl_q[CTRL_EN]) begin
               state_d = STOPPED;
            end else if (cnt_q == cmp_q) begin
               hit = 1'b1;
               if (ctrl_q[CTRL_AUTORLD]) cnt_d = '0;
               else                      state_d = EXPIRED;
            end else begin
               cnt_d = cnt_q + DATA_W'(1);
            end
         end
         EXPIRED: begin
            if (!ctrl_q[CTRL_EN])  state_d = STOPPED;
            else if (wr_i.wr_cnt)  state_d = RUNNING;
         end
         default: state_d = STOPPED;
      endcase

      // CPU writes override the count path; a same-cycle match beats a status clear.
      if (wr_i.wr_cnt)  cnt_d  = wr_i.wdata;
      if (wr_i.wr_cmp)  cmp_d  = wr_i.wdata;
      if (wr_i.wr_ctrl) ctrl_d = wr_i.wdata[CTRL_W-1:0];
      if (wr_i.wr_stat && wr_i.wdata[0]) match_d = 1'b0;
      if (hit) match_d = 1'b1;

      irq_d = match_q & ctrl_q[CTRL_IRQEN];
   end

   assign cnt_o   = cnt_q;
   assign cmp_o   = cmp_q;
   assign ctrl_o  = ctrl_q;
   assign match_o = match_q;
   assign irq_o   = irq_q;

endmodule

// File: rtl/mem_bus_responder.sv
// CPU memory-port responder: 256-word RAM plus memory-mapped timer, registered read data and bus error.
module mem_bus_responder
   import mem_bus_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] Address,
   input  logic              Wr,
   input  logic [DATA_W-1:0] Datain,
   output logic [DATA_W-1:0] Dataout,
   output logic              Irq,
   output logic              BusErr
);

   localparam logic [WADDR_W-1:0] W_RAM_TOP = word_addr(RAM_TOP);
   localparam logic [WADDR_W-1:0] W_CNT     = word_addr(TIMER_CNT);
   localparam logic [WADDR_W-1:0] W_CMP     = word_addr(TIMER_CMP);
   localparam logic [WADDR_W-1:0] W_CTRL    = word_addr(TIMER_CTRL);
   localparam logic [WADDR_W-1:0] W_STAT    = word_addr(TIMER_STAT);
   localparam logic [WADDR_W-1:0] W_END     = word_addr(MAP_END);

   logic [WADDR_W-1:0]   waddr;
   logic [RAM_IDX_W-1:0] ram_idx;
   logic                 is_ram, is_err;
   logic                 unused_addr_lsb;

   logic [DATA_W-1:0]    ram_q [RAM_DEPTH];
   logic [DATA_W-1:0]    dataout_q, dataout_d;
   logic                 buserr_q;

   timer_wr_t            tmr_wr;
   logic [DATA_W-1:0]    tmr_cnt, tmr_cmp;
   logic [CTRL_W-1:0]    tmr_ctrl;
   logic                 tmr_match;
   logic                 tmr_irq;

   // Byte-lane bits play no part in decode.
   assign waddr           = word_addr(Address);
   assign unused_addr_lsb = ^Address[1:0];
   assign ram_idx         = waddr[RAM_IDX_W-1:0];
   assign is_ram          = (waddr <= W_RAM_TOP);
   assign is_err          = (waddr >= W_END);

   always_comb begin
      tmr_wr         = '0;
      tmr_wr.wr_cnt  = Wr && (waddr == W_CNT);
      tmr_wr.wr_cmp  = Wr && (waddr == W_CMP);
      tmr_wr.wr_ctrl = Wr && (waddr == W_CTRL);
      tmr_wr.wr_stat = Wr && (waddr == W_STAT);
      tmr_wr.wdata   = Datain;
   end

   timer_unit u_timer (
      .clk_i   (Clk),
      .rst_ni  (Reset),
      .wr_i    (tmr_wr),
      .cnt_o   (tmr_cnt),
      .cmp_o   (tmr_cmp),
      .ctrl_o  (tmr_ctrl),
      .match_o (tmr_match),
      .irq_o   (tmr_irq)
   );

   // RAM keeps its contents across reset.
   always_ff @(posedge Clk) begin
      if (Wr && is_ram) ram_q[ram_idx] <= Datain;
   end

   // Read mux sees pre-update state, so a write cycle returns the old value.
   always_comb begin
      dataout_d = '0;
      if (is_ram)                dataout_d = ram_q[ram_idx];
      else if (waddr == W_CNT)   dataout_d = tmr_cnt;
      else if (waddr == W_CMP)   dataout_d = tmr_cmp;
      else if (waddr == W_CTRL)  dataout_d = DATA_W'(tmr_ctrl);
      else if (waddr == W_STAT)  dataout_d = DATA_W'(tmr_match);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         dataout_q <= '0;
         buserr_q  <= 1'b0;
      end else begin
         dataout_q <= dataout_d;
         buserr_q  <= is_err;
      end
   end

   assign Dataout = dataout_q;
   assign BusErr  = buserr_q;
   assign Irq     = tmr_irq;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed-vector bench for mem_bus_responder: RAM path, timer modes, bus errors and async reset.
module tb_mem_bus_responder;
   import mem_bus_pkg::*;

   logic        Clk;
   logic        Reset;
   logic [31:0] Address;
   logic        Wr;
   logic [31:0] Datain;
   logic [31:0] Dataout;
   logic        Irq;
   logic        BusErr;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_do;
      logic        chk_do;
      logic        exp_irq;
      logic        exp_berr;
   } vec_t;

   vec_t vq[$];

   mem_bus_responder dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Address (Address),
      .Wr      (Wr),
      .Datain  (Datain),
      .Dataout (Dataout),
      .Irq     (Irq),
      .BusErr  (BusErr)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   task automatic add(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] e, input logic c, input logic irq, input logic be);
      vec_t v;
      v.addr = a; v.wr = w; v.wdata = d; v.exp_do = e; v.chk_do = c;
      v.exp_irq = irq; v.exp_berr = be;
      vq.push_back(v);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic irq);
      add(a, 1'b0, 32'h0, e, 1'b1, irq, 1'b0);
   endtask

   task automatic wrv(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e, input logic irq);
      add(a, 1'b1, d, e, 1'b1, irq, 1'b0);
   endtask

   // Apply queued vectors one per cycle, checking outputs just after each edge.
   task automatic run_vecs(input string phase);
      for (int i = 0; i < vq.size(); i++) begin
         Address = vq[i].addr;
         Wr      = vq[i].wr;
         Datain  = vq[i].wdata;
         @(posedge Clk);
         #1;
         if (vq[i].chk_do) check($sformatf("%s v%0d dout", phase, i), Dataout, vq[i].exp_do);
         check($sformatf("%s v%0d irq", phase, i), 32'(Irq), 32'(vq[i].exp_irq));
         check($sformatf("%s v%0d berr", phase, i), 32'(BusErr), 32'(vq[i].exp_berr));
      end
      vq.delete();
      Address = 32'h0;
      Wr      = 1'b0;
      Datain  = 32'h0;
   endtask

   initial begin
      Reset   = 1'b0;
      Address = 32'h0;
      Wr      = 1'b0;
      Datain  = 32'h0;
      #12;
      check("rst dout", Dataout, 32'h0);
      check("rst irq", 32'(Irq), 32'h0);
      check("rst berr", 32'(BusErr), 32'h0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;

      // Reset values and RAM path
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CMP, 32'hFFFF_FFFF, 1'b0);
      rd(TIMER_CTRL, 32'h0, 1'b0);
      rd(TIMER_STAT, 32'h0, 1'b0);
      add(32'h010, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0);
      rd(32'h010, 32'hDEAD_BEEF, 1'b0);
      rd(32'h013, 32'hDEAD_BEEF, 1'b0);
      wrv(32'h011, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
      rd(32'h010, 32'h1234_5678, 1'b0);
      add(32'h3FC, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 1'b0);
      rd(32'h3FF, 32'hA5A5_A5A5, 1'b0);
      rd(32'h010, 32'h1234_5678, 1'b0);
      wrv(TIMER_CTRL, 32'hFFFF_FFF8, 32'h0, 1'b0);
      rd(TIMER_CTRL, 32'h0, 1'b0);
      // Out-of-map accesses
      add(32'h500, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      add(32'h410, 1'b1, 32'h77, 32'h0, 1'b1, 1'b0, 1'b1);
      add(32'h1010, 1'b1, 32'hBAD, 32'h0, 1'b1, 1'b0, 1'b1);
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(32'h010, 32'h1234_5678, 1'b0);
      // One-shot: CMP=5, CTRL=EN|IRQEN
      wrv(TIMER_CMP, 32'h5, 32'hFFFF_FFFF, 1'b0);
      wrv(TIMER_CTRL, 32'h3, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h1, 1'b0);
      rd(TIMER_CNT, 32'h2, 1'b0);
      rd(TIMER_CNT, 32'h3, 1'b0);
      rd(TIMER_CNT, 32'h4, 1'b0);
      rd(TIMER_CNT, 32'h5, 1'b0);
      rd(TIMER_CNT, 32'h5, 1'b1);
      rd(TIMER_STAT, 32'h1, 1'b1);
      rd(TIMER_CNT, 32'h5, 1'b1);
      wrv(TIMER_CNT, 32'h2, 32'h5, 1'b1);
      rd(TIMER_CNT, 32'h2, 1'b1);
      rd(TIMER_CNT, 32'h3, 1'b1);
      wrv(TIMER_CTRL, 32'h0, 32'h3, 1'b1);
      rd(TIMER_CNT, 32'h5, 1'b0);
      rd(TIMER_CNT, 32'h5, 1'b0);
      // Auto-reload: CMP=3, CTRL=7, status clear with and without coinciding match
      wrv(TIMER_CNT, 32'h0, 32'h5, 1'b0);
      wrv(TIMER_CMP, 32'h3, 32'h5, 1'b0);
      wrv(TIMER_STAT, 32'h1, 32'h1, 1'b0);
      rd(TIMER_STAT, 32'h0, 1'b0);
      wrv(TIMER_CTRL, 32'h7, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h1, 1'b0);
      rd(TIMER_CNT, 32'h2, 1'b0);
      rd(TIMER_CNT, 32'h3, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b1);
      rd(TIMER_CNT, 32'h1, 1'b1);
      rd(TIMER_CNT, 32'h2, 1'b1);
      wrv(TIMER_STAT, 32'h1, 32'h1, 1'b1);
      rd(TIMER_STAT, 32'h1, 1'b1);
      wrv(TIMER_STAT, 32'h1, 32'h1, 1'b1);
      rd(TIMER_STAT, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h3, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b1);
      // Write/increment collision, then wrap-around
      wrv(TIMER_CNT, 32'h100, 32'h1, 1'b1);
      rd(TIMER_CNT, 32'h100, 1'b1);
      wrv(TIMER_CTRL, 32'h1, 32'h7, 1'b1);
      wrv(TIMER_CMP, 32'h10, 32'h3, 1'b0);
      wrv(TIMER_CNT, 32'hFFFF_FFFE, 32'h103, 1'b0);
      rd(TIMER_CNT, 32'hFFFF_FFFE, 1'b0);
      rd(TIMER_CNT, 32'hFFFF_FFFF, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h1, 1'b0);
      // Running with Irq high ahead of the mid-count reset
      wrv(TIMER_CTRL, 32'h7, 32'h1, 1'b0);
      wrv(TIMER_CNT, 32'h0, 32'h3, 1'b1);
      rd(TIMER_CNT, 32'h0, 1'b1);
      rd(TIMER_CNT, 32'h1, 1'b1);
      run_vecs("main");

      // Asynchronous reset between clock edges
      #2;
      Reset = 1'b0;
      #1;
      check("async irq", 32'(Irq), 32'h0);
      check("async dout", Dataout, 32'h0);
      check("async berr", 32'(BusErr), 32'h0);
      check("async cnt", dut.u_timer.cnt_q, 32'h0);
      check("async state", 32'(dut.u_timer.state_q), 32'(STOPPED));
      @(posedge Clk);
      #1;
      check("held irq", 32'(Irq), 32'h0);
      Reset = 1'b1;

      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CNT, 32'h0, 1'b0);
      rd(TIMER_CTRL, 32'h0, 1'b0);
      rd(TIMER_CMP, 32'hFFFF_FFFF, 1'b0);
      rd(TIMER_STAT, 32'h0, 1'b0);
      rd(32'h010, 32'h1234_5678, 1'b0);
      rd(32'h3FC, 32'hA5A5_A5A5, 1'b0);
      run_vecs("post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
